// File: rtl/mc_cu.sv
// Multi-cycle control unit for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB
// over a shared memory port, counts retired instructions and traps illegal opcodes.
module mc_cu #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int MEM_LAT       = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             irwrite,
  output logic             wmem,
  output logic             wreg,
  output logic             iord,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic             shift,
  output logic             sext,
  output logic             alu_a_pc,
  output logic [1:0]       alu_b_sel,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t         state_reg, state_next;
  logic [WCW-1:0] wcnt_reg, wcnt_next;
  logic           illegal_reg;
  logic [CNT_W-1:0] instret_reg;

  // Instruction decode
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic is_shift, aluimm, legal;
  logic [3:0] alu_op;

  assign r_type = (op == 6'h00);
  assign i_add  = r_type & (func == 6'h20);
  assign i_sub  = r_type & (func == 6'h22);
  assign i_and  = r_type & (func == 6'h24);
  assign i_or   = r_type & (func == 6'h25);
  assign i_xor  = r_type & (func == 6'h26);
  assign i_sll  = r_type & (func == 6'h00);
  assign i_srl  = r_type & (func == 6'h02);
  assign i_sra  = r_type & (func == 6'h03);
  assign i_jr   = r_type & (func == 6'h08);
  assign i_addi = (op == 6'h08);
  assign i_andi = (op == 6'h0c);
  assign i_ori  = (op == 6'h0d);
  assign i_xori = (op == 6'h0e);
  assign i_lw   = (op == 6'h23);
  assign i_sw   = (op == 6'h2b);
  assign i_beq  = (op == 6'h04);
  assign i_bne  = (op == 6'h05);
  assign i_lui  = (op == 6'h0f);
  assign i_j    = (op == 6'h02);
  assign i_jal  = (op == 6'h03);

  assign is_shift = i_sll | i_srl | i_sra;
  assign aluimm   = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
  assign legal    = i_add | i_sub | i_and | i_or | i_xor | is_shift | i_jr |
                    aluimm | i_beq | i_bne | i_j | i_jal;
  assign regrt    = aluimm;
  assign sext     = i_addi | i_lw | i_sw | i_beq | i_bne;

  always_comb begin
    alu_op = 4'b0000;
    if (i_sub | i_beq | i_bne)  alu_op = 4'b0100;
    else if (i_and | i_andi)    alu_op = 4'b0001;
    else if (i_or | i_ori)      alu_op = 4'b0101;
    else if (i_xor | i_xori)    alu_op = 4'b0010;
    else if (i_lui)             alu_op = 4'b0110;
    else if (i_sll)             alu_op = 4'b0011;
    else if (i_srl)             alu_op = 4'b0111;
    else if (i_sra)             alu_op = 4'b1111;
  end

  // Memory completion: either external handshake or a fixed dwell counter
  logic mem_phase, done, wcnt_done;
  assign mem_phase = (state_reg == S_IF) || (state_reg == S_MEM);
  assign wcnt_done = (wcnt_reg == WCW'(MEM_LAT - 1));

  generate
    if (MEM_HANDSHAKE) begin : g_hs
      assign done = mem_ready;
    end else begin : g_fixed
      assign done = wcnt_done;
    end
  endgenerate

  assign wcnt_next = (mem_phase && !done) ? wcnt_reg + 1'b1 : '0;

  // Raw enables before the reset gate
  logic pcwrite_raw, irwrite_raw, wmem_raw, wreg_raw, retire_raw;

  always_comb begin
    state_next  = state_reg;
    pcwrite_raw = 1'b0;
    irwrite_raw = 1'b0;
    wmem_raw    = 1'b0;
    wreg_raw    = 1'b0;
    retire_raw  = 1'b0;
    iord        = 1'b0;
    m2reg       = 1'b0;
    jal         = 1'b0;
    shift       = 1'b0;
    alu_a_pc    = 1'b0;
    alu_b_sel   = 2'b00;
    aluc        = 4'b0000;
    pcsource    = 2'b00;
    case (state_reg)
      S_IF: begin
        alu_a_pc  = 1'b1;
        alu_b_sel = 2'b01;
        if (done) begin
          pcwrite_raw = 1'b1;
          irwrite_raw = 1'b1;
          state_next  = S_ID;
        end
      end
      S_ID: begin
        alu_a_pc  = 1'b1;
        alu_b_sel = 2'b11;
        if (!legal) begin
          state_next = S_TRAP;
        end else if (i_j | i_jal) begin
          pcwrite_raw = 1'b1;
          pcsource    = 2'b11;
          wreg_raw    = i_jal;
          jal         = i_jal;
          retire_raw  = 1'b1;
          state_next  = S_IF;
        end else if (i_jr) begin
          pcwrite_raw = 1'b1;
          pcsource    = 2'b10;
          retire_raw  = 1'b1;
          state_next  = S_IF;
        end else begin
          state_next = S_EXE;
        end
      end
      S_EXE: begin
        alu_b_sel = aluimm ? 2'b10 : 2'b00;
        aluc      = alu_op;
        shift     = is_shift;
        if (i_beq | i_bne) begin
          // Target was latched into ALU-out during ID
          pcwrite_raw = (i_beq & z) | (i_bne & ~z);
          pcsource    = 2'b01;
          retire_raw  = 1'b1;
          state_next  = S_IF;
        end else if (i_lw | i_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        iord     = 1'b1;
        wmem_raw = i_sw;
        if (done) begin
          if (i_sw) begin
            retire_raw = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        wreg_raw   = 1'b1;
        m2reg      = i_lw;
        retire_raw = 1'b1;
        state_next = S_IF;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_IF;
      end
    endcase
  end

  // Reset aborts the current instruction: no write may land in that cycle
  assign pcwrite = pcwrite_raw & ~reset;
  assign irwrite = irwrite_raw & ~reset;
  assign wmem    = wmem_raw & ~reset;
  assign wreg    = wreg_raw & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IF;
      wcnt_reg    <= '0;
      illegal_reg <= 1'b0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      if (state_next == S_TRAP) illegal_reg <= 1'b1;
      if (retire_raw) instret_reg <= instret_reg + 1'b1;
    end
  end

  assign state   = state_reg;
  assign illegal = illegal_reg;
  assign instret = instret_reg;

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: per-cycle expectations are queued by the stimulus
// process and compared by a negedge monitor against handshake and fixed-latency instances.
module tb_mc_cu;

  localparam int D = -1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, func;
  logic        z, mr;

  logic        pcw_a, irw_a, wm_a, wr_a, iord_a, rgt_a, m2r_a, jal_a, sh_a, sx_a, apc_a, ill_a;
  logic [1:0]  bs_a, pcs_a;
  logic [3:0]  ac_a;
  logic [2:0]  st_a;
  logic [31:0] ir_a;

  logic        pcw_b, irw_b, wm_b, wr_b, iord_b, rgt_b, m2r_b, jal_b, sh_b, sx_b, apc_b, ill_b;
  logic [1:0]  bs_b, pcs_b;
  logic [3:0]  ac_b;
  logic [2:0]  st_b;
  logic [31:0] ir_b;

  mc_cu #(.MEM_HANDSHAKE(1'b1), .MEM_LAT(1), .CNT_W(32)) dut_a (
    .clock(clk), .reset(rst), .op(op), .func(func), .z(z), .mem_ready(mr),
    .pcwrite(pcw_a), .irwrite(irw_a), .wmem(wm_a), .wreg(wr_a), .iord(iord_a),
    .regrt(rgt_a), .m2reg(m2r_a), .jal(jal_a), .shift(sh_a), .sext(sx_a),
    .alu_a_pc(apc_a), .alu_b_sel(bs_a), .aluc(ac_a), .pcsource(pcs_a),
    .state(st_a), .illegal(ill_a), .instret(ir_a)
  );

  mc_cu #(.MEM_HANDSHAKE(1'b0), .MEM_LAT(3), .CNT_W(32)) dut_b (
    .clock(clk), .reset(rst), .op(op), .func(func), .z(z), .mem_ready(mr),
    .pcwrite(pcw_b), .irwrite(irw_b), .wmem(wm_b), .wreg(wr_b), .iord(iord_b),
    .regrt(rgt_b), .m2reg(m2r_b), .jal(jal_b), .shift(sh_b), .sext(sx_b),
    .alu_a_pc(apc_b), .alu_b_sel(bs_b), .aluc(ac_b), .pcsource(pcs_b),
    .state(st_b), .illegal(ill_b), .instret(ir_b)
  );

  always #5 clk = ~clk;

  logic [26:0] act_a, act_b;
  assign act_a = {st_a, pcw_a, irw_a, wm_a, wr_a, iord_a, m2r_a, jal_a, pcs_a, ac_a, bs_a, ill_a, ir_a[7:0]};
  assign act_b = {st_b, pcw_b, irw_b, wm_b, wr_b, iord_b, m2r_b, jal_b, pcs_b, ac_b, bs_b, ill_b, ir_b[7:0]};

  typedef struct {
    bit          sel;
    string       nm;
    logic [26:0] v;
    logic [26:0] m;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic put(inout logic [26:0] v, inout logic [26:0] m,
                     input int val, input int lsb, input int w);
    if (val >= 0) begin
      for (int i = 0; i < w; i++) begin
        v[lsb+i] = val[i];
        m[lsb+i] = 1'b1;
      end
    end
  endtask

  // One call per clock: queue this cycle's expectation, then advance.
  // Fields: state, {pcwrite,irwrite,wmem,wreg}, iord, m2reg, jal, pcsource,
  // aluc, alu_b_sel, illegal, instret[7:0]; D = don't care.
  task automatic cyc(input string nm, input bit sel, input int st, input int en,
                     input int io, input int m2r, input int jl, input int pcs,
                     input int ac, input int bs, input int il, input int ir);
    exp_t e;
    e.sel = sel;
    e.nm  = nm;
    e.v   = '0;
    e.m   = '0;
    put(e.v, e.m, st,  24, 3);
    put(e.v, e.m, en,  20, 4);
    put(e.v, e.m, io,  19, 1);
    put(e.v, e.m, m2r, 18, 1);
    put(e.v, e.m, jl,  17, 1);
    put(e.v, e.m, pcs, 15, 2);
    put(e.v, e.m, ac,  11, 4);
    put(e.v, e.m, bs,   9, 2);
    put(e.v, e.m, il,   8, 1);
    put(e.v, e.m, ir,   0, 8);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [26:0] act;
      e   = q.pop_front();
      act = e.sel ? act_b : act_a;
      checks++;
      if (((act ^ e.v) & e.m) != 27'd0) begin
        failures++;
        $display("FAIL %s actual=%b required=%b care=%b", e.nm, act, e.v, e.m);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; op = 6'h00; func = 6'h20; z = 1'b0; mr = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", 0, D, 'b0000, D, D, D, D, D, D, D, D);
    rst = 1'b0;

    // add, zero-wait handshake: 0,1,2,4 then next IF
    cyc("add_if",  0, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 0);
    cyc("add_id",  0, 1, 'b0000, D, D, 0, D, 0, 3, 0, 0);
    cyc("add_exe", 0, 2, 'b0000, D, D, D, D, 0, 0, 0, 0);
    cyc("add_wb",  0, 4, 'b0001, D, 0, D, D, D, D, 0, 0);

    // beq taken then not taken
    op = 6'h04; func = 6'h00;
    cyc("beq1_if",  0, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 1);
    cyc("beq1_id",  0, 1, 'b0000, D, D, 0, D, 0, 3, 0, 1);
    z = 1'b1;
    cyc("beq1_exe", 0, 2, 'b1000, D, D, D, 1, 4, 0, 0, 1);
    z = 1'b0;
    cyc("beq2_if",  0, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 2);
    cyc("beq2_id",  0, 1, 'b0000, D, D, 0, D, 0, 3, 0, 2);
    cyc("beq2_exe", 0, 2, 'b0000, D, D, D, D, 4, 0, 0, 2);

    // jal
    op = 6'h03;
    cyc("jal_if", 0, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 3);
    cyc("jal_id", 0, 1, 'b1001, D, D, 1, 3, D, D, 0, 3);

    // illegal opcode traps in the third cycle and stays quiet
    op = 6'h3f;
    cyc("ill_if", 0, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 4);
    cyc("ill_id", 0, 1, 'b0000, D, D, D, D, D, D, 0, 4);
    for (int i = 0; i < 10; i++)
      cyc("trap", 0, 7, 'b0000, D, D, D, D, D, D, 1, 4);
    rst = 1'b1;
    cyc("trap_rst", 0, 7, 'b0000, D, D, D, D, D, D, 1, 4);
    rst = 1'b0;

    // sw with one fetch wait, a stalled MEM, then reset mid-instruction
    op = 6'h2b; mr = 1'b0;
    cyc("sw_if_wait", 0, 0, 'b0000, 0, D, D, D, 0, 1, 0, 0);
    mr = 1'b1;
    cyc("sw_if",  0, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 0);
    cyc("sw_id",  0, 1, 'b0000, D, D, 0, D, 0, 3, 0, 0);
    cyc("sw_exe", 0, 2, 'b0000, D, D, D, D, 0, 2, 0, 0);
    mr = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc("sw_mem", 0, 3, 'b0010, 1, D, D, D, D, D, 0, 0);
    rst = 1'b1;
    cyc("sw_rst", 0, 3, 'b0000, D, D, D, D, D, D, 0, 0);
    rst = 1'b0;

    // lw on the fixed-latency instance (MEM_LAT=3); mem_ready held high is ignored
    op = 6'h23; mr = 1'b1;
    cyc("sw_after_rst", 0, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 0);
    q.delete();
    rst = 1'b1;
    cyc("lw_reset", 1, D, 'b0000, D, D, D, D, D, D, D, D);
    rst = 1'b0;
    cyc("lw_if1",  1, 0, 'b0000, 0, D, D, D, 0, 1, 0, 0);
    cyc("lw_if2",  1, 0, 'b0000, 0, D, D, D, 0, 1, 0, 0);
    cyc("lw_if3",  1, 0, 'b1100, 0, D, D, 0, 0, 1, 0, 0);
    cyc("lw_id",   1, 1, 'b0000, D, D, 0, D, 0, 3, 0, 0);
    cyc("lw_exe",  1, 2, 'b0000, D, D, D, D, 0, 2, 0, 0);
    cyc("lw_mem1", 1, 3, 'b0000, 1, D, D, D, D, D, 0, 0);
    cyc("lw_mem2", 1, 3, 'b0000, 1, D, D, D, D, D, 0, 0);
    cyc("lw_mem3", 1, 3, 'b0000, 1, D, D, D, D, D, 0, 0);
    cyc("lw_wb",   1, 4, 'b0001, D, 1, D, D, D, D, 0, 0);
    cyc("lw_next", 1, 0, 'b0000, 0, D, D, D, 0, 1, 0, 1);

    @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
